stage_sequencer: RTL
====================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001: Parameter NUM_STAGES, default 4, number of sequenced stages (fetch, decode, execute, writeback); legal range 2..8.
REQ-002: Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003: Parameter MAX_STALL, default 15, consecutive stall cycles allowed per stage before timeout; 0 disables the watchdog.
REQ-004: clk  input  1  clock; all state updates on rising edge.
REQ-005: reset  input  1  reset, synchronous, active-high.
REQ-006: start  input  1  leave IDLE or HALTED and begin a new instruction at stage 0.
REQ-007: halt_req  input  1  request stop at the next instruction boundary.
REQ-008: stage_ready  input  NUM_STAGES  bit k high = stage k work complete this cycle.
REQ-009: en_prog_mem  output  1  program memory enable.
REQ-010: stage_en  output  NUM_STAGES  one-hot enable of the active stage.
REQ-011: busy  output  1  high while any stage is active.
REQ-012: halted  output  1  high in HALTED state.
REQ-013: instr_done  output  1  one-cycle pulse per retired instruction.
REQ-014: retire_count  output  CNT_W  retired instructions, wrapping.
REQ-015: timeout_err  output  1  sticky stall-watchdog error flag.

Function
REQ-016: States SHALL be IDLE, STAGE(k) for k = 0..NUM_STAGES-1, and HALTED; all outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path.
REQ-017: IDLE: en_prog_mem=1, stage_en=0, busy=0; start=1 -> STAGE(0) next cycle; otherwise remain.
REQ-018: STAGE(k): stage_en = 1<<k, busy=1; stage_ready[k]=0 -> remain (stall); stage_ready[k]=1 and k<NUM_STAGES-1 -> STAGE(k+1).
REQ-019: en_prog_mem SHALL also be 1 in STAGE(NUM_STAGES-1) (prefetch) and 0 in every other STAGE(k) and in HALTED.
REQ-020: STAGE(NUM_STAGES-1) with stage_ready=1 is the instruction boundary; next state is HALTED if the halt latch is set, else STAGE(0).
REQ-021: At the boundary, instr_done SHALL pulse high for exactly the following cycle and retire_count SHALL increment in that same cycle, wrapping from 2^CNT_W-1 to 0.
REQ-022: With all stage_ready bits held high, back-to-back instructions SHALL take exactly NUM_STAGES cycles each; start sampled in IDLE gives STAGE(0) on the next cycle.
REQ-023: halt_req SHALL set a sticky halt latch in any state; the latch clears on entering HALTED; halt_req never aborts an instruction mid-stage.
REQ-024: HALTED: halted=1, stage_en=0, busy=0; start=1 -> STAGE(0) and timeout_err cleared.
REQ-025: start and halt_req sampled high together in IDLE or HALTED SHALL execute exactly one instruction, then enter HALTED (single-step).
REQ-026: start while busy SHALL be ignored.
REQ-027: Stall counter SHALL count consecutive cycles with stage_ready[k]=0 in the current stage and clear on every stage advance; with MAX_STALL>0, when it reaches MAX_STALL while ready is still 0, the next state is HALTED with timeout_err=1, no instr_done, and retire_count unchanged.
REQ-028: stage_ready bits of non-active stages SHALL be ignored.

Reset
REQ-029: reset=1 at a rising edge SHALL force IDLE from any state, including mid-stall, and set en_prog_mem=1, stage_en=0, busy=0, halted=0, instr_done=0, retire_count=0, timeout_err=0, halt latch=0, stall counter=0.

Verification
REQ-030: NUM_STAGES=4, all ready=1, start pulse -> stage_en 0001,0010,0100,1000 repeating every 4 cycles; instr_done every 4th cycle; retire_count=3 after 12 cycles.
REQ-031: stage_ready[2]=0 for 5 cycles -> stage_en=0100 held 6 cycles; instruction takes 9 cycles; timeout_err stays 0.
REQ-032: halt_req pulsed during STAGE(1) -> instruction completes, instr_done pulses, next state HALTED, halted=1, stage_en=0.
REQ-033: In HALTED, start+halt_req together -> one 4-cycle instruction, retire_count +1, back in HALTED.
REQ-034: MAX_STALL=15, stage_ready[1] held 0 -> HALTED with timeout_err=1 after the 15th stall cycle; a following start clears timeout_err.
REQ-035: CNT_W=4, 16 instructions retired -> retire_count wraps to 0; reset asserted mid-STAGE(2) -> IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: steps one instruction through NUM_STAGES one-hot stage enables,
// with halt/single-step control, a retire counter and a per-stage stall watchdog.
`default_nettype none

module stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 16,
  parameter int MAX_STALL  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  halt_req_i,
  input  logic [NUM_STAGES-1:0] stage_ready_i,
  output logic                  en_prog_mem_o,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic                  busy_o,
  output logic                  halted_o,
  output logic                  instr_done_o,
  output logic [CNT_W-1:0]      retire_count_o,
  output logic                  timeout_err_o
);

  localparam int IDX_W   = $clog2(NUM_STAGES);
  localparam int STALL_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_STAGES - 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT  = STALL_W'((MAX_STALL > 0) ? MAX_STALL - 1 : 0);
  localparam logic [NUM_STAGES-1:0] ONE_HOT0  = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STAGE  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 halt_q, halt_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 terr_q, terr_d;
  logic                 w_ready;

  // Only the active stage's ready bit is ever consulted.
  assign w_ready = stage_ready_i[idx_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      stall_q <= '0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stall_q <= stall_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      count_q <= count_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stall_d = stall_q;
    halt_d  = halt_q | halt_req_i;
    done_d  = 1'b0;
    count_d = count_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_STAGE;
          idx_d   = '0;
          stall_d = '0;
        end
      end
      S_HALTED: begin
        if (start_i) begin
          state_d = S_STAGE;
          idx_d   = '0;
          stall_d = '0;
          terr_d  = 1'b0;
        end
      end
      S_STAGE: begin
        if (w_ready) begin
          stall_d = '0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
            idx_d   = '0;
            if (halt_q | halt_req_i) begin
              state_d = S_HALTED;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (MAX_STALL > 0) begin
          // This cycle is the MAX_STALL-th consecutive stall: give up.
          if (stall_q == STALL_LIMIT) begin
            state_d = S_HALTED;
            terr_d  = 1'b1;
            stall_d = '0;
            idx_d   = '0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        stall_d = '0;
      end
    endcase
    // The halt request is consumed by the transition into HALTED.
    if (state_q == S_STAGE && state_d == S_HALTED) begin
      halt_d = 1'b0;
    end
  end

  assign stage_en_o     = (state_q == S_STAGE) ? (ONE_HOT0 << idx_q) : '0;
  assign en_prog_mem_o  = (state_q == S_IDLE) || (state_q == S_STAGE && idx_q == LAST_IDX);
  assign busy_o         = (state_q == S_STAGE);
  assign halted_o       = (state_q == S_HALTED);
  assign instr_done_o   = done_q;
  assign retire_count_o = count_q;
  assign timeout_err_o  = terr_q;

endmodule

`default_nettype wire
